pipeline_writeback: RTL and testbench
=====================================

Name: pipeline_writeback

Overview:
RV32I write-back stage. It is the writer end of the register-file write port that the decode stage consumes through write_reg/write_data/reg_write.
- Accepts completed instructions from the memory stage.
- Selects the result source, and extracts and extends load data.
- Waits for late load responses.
- Drives a single registered register-file write pulse per retired instruction.
- Maintains a retired-instruction counter.

Parameters:
INSTRET_W, 64, width of retired-instruction counter
ZERO_X0, 1, when 1 suppress reg_write_o for rd == 0

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  memory stage presents an instruction
ready_o  out  1  write-back can accept; transfer occurs when valid_i & ready_o
rd_i  in  5  destination register address
reg_write_en_i  in  1  instruction writes rd
wb_sel_i  in  2  result source: 00 ALU, 01 LOAD, 10 PC+4 (JAL/JALR), 11 IMM (LUI)
funct3_i  in  3  load width/sign code
addr_lo_i  in  2  load address bits [1:0]
alu_result_i  in  32  ALU result (also AUIPC result)
pc_plus4_i  in  32  link address
imm_i  in  32  U-type immediate, already shifted
mem_rvalid_i  in  1  load data valid
mem_rdata_i  in  32  raw load word from data memory
write_reg_o  out  5  register-file write address
write_data_o  out  32  register-file write data
reg_write_o  out  1  register-file write enable, one-cycle pulse per write
instret_o  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (async, any state): state IDLE, write_reg_o 0, write_data_o 0, reg_write_o 0, instret_o 0. A reset during WAIT_LOAD abandons the load and produces no write.
- The FSM has two states, IDLE and WAIT_LOAD. ready_o = 1 only in IDLE (combinational from state).
- **IDLE, accept of a non-load** (wb_sel_i != 01), at edge t:
  - Outputs are registered and take effect at edge t, visible in cycle t+1.
  - write_reg_o = rd_i.
  - write_data_o = selected source.
  - reg_write_o = reg_write_en_i & ~(ZERO_X0 & rd_i == 0).
  - Latency is 1 cycle. The state stays IDLE, so back-to-back accepts are possible every cycle.
- **IDLE, accept of a load** with mem_rvalid_i = 1 in the same cycle: same as a non-load, with the extracted load data as the source.
- **IDLE, accept of a load** with mem_rvalid_i = 0:
  - Capture rd_i, reg_write_en_i, funct3_i and addr_lo_i.
  - Go to WAIT_LOAD. reg_write_o is 0 next cycle.
- **WAIT_LOAD:**
  - ready_o = 0 and valid_i is ignored.
  - On the first cycle with mem_rvalid_i = 1: register the write using the captured fields and the extracted mem_rdata_i, and return to IDLE.
  - The wait may last any number of cycles; there is no timeout.
- mem_rvalid_i is ignored in IDLE unless a load is being accepted that cycle.
- **Load extraction** (b = addr_lo_i*8, h = addr_lo_i[1]*16):
  - 000 LB: sign-extend rdata[b+7:b].
  - 001 LH: sign-extend rdata[h+15:h]; addr_lo_i[0] is ignored, since alignment is checked upstream.
  - 010 LW: full word; addr_lo_i is ignored.
  - 100 LBU: zero-extend rdata[b+7:b].
  - 101 LHU: zero-extend rdata[h+15:h].
  - 011/110/111: write_data_o = 0 and reg_write_o forced 0; the instruction still retires.
- **Output hold:** write_reg_o and write_data_o update on every retire, even when reg_write_o is suppressed, and hold otherwise. reg_write_o is 0 on every cycle without a retire.
- **instret_o** increments by 1 at every retire edge, regardless of reg_write_en_i and of rd. It wraps to 0 after all ones.

Test Plan:
- ALU retire: valid_i=1, wb_sel=00, rd=5, alu_result=0x1234_5678, en=1 → next cycle reg_write_o=1, write_reg_o=5, write_data_o=0x12345678, instret_o=1.
- x0 suppression and JAL link:
  - Accept rd=0, en=1, wb_sel=10, pc_plus4=0x104 → reg_write_o=0, write_data_o=0x104, instret_o increments.
  - With ZERO_X0=0 → reg_write_o=1.
- Load extraction, with mem_rdata=0x80F1_7F82 and rvalid same cycle:
  - LB addr_lo=0 → 0xFFFFFF82.
  - LBU addr_lo=3 → 0x00000080.
  - LH addr_lo=2 → 0xFFFF80F1.
  - LHU addr_lo=0 → 0x00007F82.
  - LW → 0x80F17F82.
- Late load:
  - Accept LW rd=7 with rvalid=0 → ready_o=0 for 3 cycles with valid_i held high and no write.
  - rvalid=1, rdata=0xDEADBEEF → next cycle reg_write_o=1, rd=7, data=0xDEADBEEF, then ready_o=1.
- Reset in WAIT_LOAD: assert rst_i asynchronously mid-wait → ready_o=1, all outputs 0 immediately, and a later rvalid produces no write.
- Back-to-back: 4 consecutive ALU accepts rd=1..4 → 4 consecutive reg_write_o pulses in order, instret_o=4.

Source files
------------

// File: rtl/pipeline_writeback.sv
// pipeline_writeback: RV32I write-back stage; selects/extracts the result, waits for late loads,
// drives a registered register-file write pulse and counts retired instructions.
module pipeline_writeback #(
  parameter int INSTRET_W = 64,
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [4:0]           rd_i,
  input  logic                 reg_write_en_i,
  input  logic [1:0]           wb_sel_i,
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [31:0]          alu_result_i,
  input  logic [31:0]          pc_plus4_i,
  input  logic [31:0]          imm_i,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  output logic [4:0]           write_reg_o,
  output logic [31:0]          write_data_o,
  output logic                 reg_write_o,
  output logic [INSTRET_W-1:0] instret_o
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t state_q, state_d;
  logic [4:0] rd_q, rd_d, write_reg_q, write_reg_d;
  logic en_q, en_d, reg_write_q, reg_write_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] lo_q, lo_d;
  logic [31:0] write_data_q, write_data_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic waiting, is_load, accept, retire, from_load, park, en, ld_ok;
  logic [4:0] rd;
  logic [2:0] f3;
  logic [1:0] lo;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_data, src;
  assign ready_o = state_q == IDLE;
  always_comb begin
    waiting = state_q == WAIT_LOAD;
    is_load = wb_sel_i == 2'b01;
    accept = valid_i & ready_o;
    retire = waiting ? mem_rvalid_i : accept & (~is_load | mem_rvalid_i);
    park = accept & is_load & ~mem_rvalid_i;
    from_load = waiting | is_load;
    // A parked load retires with the fields captured at accept time
    rd = waiting ? rd_q : rd_i;
    en = waiting ? en_q : reg_write_en_i;
    f3 = waiting ? f3_q : funct3_i;
    lo = waiting ? lo_q : addr_lo_i;
    byte_v = 8'(mem_rdata_i >> {lo, 3'b000});
    half_v = lo[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ld_ok = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    ld_data = f3 == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
              f3 == 3'b001 ? {{16{half_v[15]}}, half_v} :
              f3 == 3'b010 ? mem_rdata_i :
              f3 == 3'b100 ? {24'h0, byte_v} :
              f3 == 3'b101 ? {16'h0, half_v} : 32'h0;
    src = wb_sel_i == 2'b00 ? alu_result_i : wb_sel_i == 2'b10 ? pc_plus4_i : imm_i;
    write_reg_d = retire ? rd : write_reg_q;
    write_data_d = retire ? (from_load ? ld_data : src) : write_data_q;
    reg_write_d = retire & en & ~(ZERO_X0 && rd == 5'd0) & (~from_load | ld_ok);
    instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    state_d = park ? WAIT_LOAD : (waiting & mem_rvalid_i) ? IDLE : state_q;
    rd_d = park ? rd_i : rd_q;
    en_d = park ? reg_write_en_i : en_q;
    f3_d = park ? funct3_i : f3_q;
    lo_d = park ? addr_lo_i : lo_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rd_q <= '0;
      en_q <= 1'b0;
      f3_q <= '0;
      lo_q <= '0;
      write_reg_q <= '0;
      write_data_q <= '0;
      reg_write_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      en_q <= en_d;
      f3_q <= f3_d;
      lo_q <= lo_d;
      write_reg_q <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q <= reg_write_d;
      instret_q <= instret_d;
    end
  end
  assign write_reg_o = write_reg_q;
  assign write_data_o = write_data_q;
  assign reg_write_o = reg_write_q;
  assign instret_o = instret_q;
endmodule

// File: tb/tb_pipeline_writeback.sv
// tb_pipeline_writeback: scoreboard bench; a spec-level model queues expected retires,
// a monitor pops one each time instret_o advances.
module tb_pipeline_writeback;
  logic clk = 1'b0, rst = 1'b1;
  logic valid = 1'b0, en = 1'b0, rv = 1'b0;
  logic [4:0] rd = '0;
  logic [1:0] sel = '0, lo = '0;
  logic [2:0] f3 = '0;
  logic [31:0] alu = '0, pc4 = '0, imm = '0, rdata = '0;
  logic ready, rw, ready0, rw0;
  logic [4:0] wreg, wreg0;
  logic [31:0] wdata, wdata0;
  logic [63:0] instret, instret0;
  always #5 clk = ~clk;
  pipeline_writeback #(.INSTRET_W(64), .ZERO_X0(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .rd_i(rd), .reg_write_en_i(en),
    .wb_sel_i(sel), .funct3_i(f3), .addr_lo_i(lo), .alu_result_i(alu), .pc_plus4_i(pc4),
    .imm_i(imm), .mem_rvalid_i(rv), .mem_rdata_i(rdata), .write_reg_o(wreg),
    .write_data_o(wdata), .reg_write_o(rw), .instret_o(instret));
  pipeline_writeback #(.INSTRET_W(64), .ZERO_X0(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready0), .rd_i(rd), .reg_write_en_i(en),
    .wb_sel_i(sel), .funct3_i(f3), .addr_lo_i(lo), .alu_result_i(alu), .pc_plus4_i(pc4),
    .imm_i(imm), .mem_rvalid_i(rv), .mem_rdata_i(rdata), .write_reg_o(wreg0),
    .write_data_o(wdata0), .reg_write_o(rw0), .instret_o(instret0));
  typedef struct {logic [4:0] rd; logic [31:0] data; logic we; logic we0; logic [63:0] cnt;} exp_t;
  exp_t q[$];
  int ncmp = 0, nfail = 0;
  bit busy = 0;
  logic [63:0] cnt = 0, last = 0;
  logic [4:0] p_rd;
  logic p_en;
  logic [2:0] p_f3;
  logic [1:0] p_lo;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", n, act, req);
    end
  endtask
  function automatic logic [32:0] ext(input logic [2:0] fn, input logic [1:0] a, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) % 256;
    h = (w >> (16 * (a / 2))) % 65536;
    case (fn)
      3'd0: return {1'b1, b >= 128 ? b - 256 : b};
      3'd1: return {1'b1, h >= 32768 ? h - 65536 : h};
      3'd2: return {1'b1, w};
      3'd4: return {1'b1, b};
      3'd5: return {1'b1, h};
      default: return 33'h0;
    endcase
  endfunction
  function automatic void retire(input logic [4:0] r, input logic e, input logic [31:0] d, input logic ok);
    exp_t x;
    cnt++;
    x.rd = r;
    x.data = d;
    x.we = e && ok && r != 0;
    x.we0 = e && ok;
    x.cnt = cnt;
    q.push_back(x);
  endfunction
  task automatic step(input logic v, input logic [4:0] r, input logic e, input logic [1:0] s,
                      input logic [2:0] fn, input logic [1:0] a, input logic [31:0] al,
                      input logic [31:0] p, input logic [31:0] im, input logic rvl, input logic [31:0] rdt);
    logic [32:0] x;
    valid = v; rd = r; en = e; sel = s; f3 = fn; lo = a; alu = al; pc4 = p; imm = im; rv = rvl; rdata = rdt;
    chk("ready", ready, !busy);
    if (busy) begin
      if (rvl) begin
        x = ext(p_f3, p_lo, rdt);
        retire(p_rd, p_en, x[31:0], x[32]);
        busy = 0;
      end
    end else if (v) begin
      if (s != 2'b01) retire(r, e, s == 2'b00 ? al : s == 2'b10 ? p : im, 1'b1);
      else if (rvl) begin
        x = ext(fn, a, rdt);
        retire(r, e, x[31:0], x[32]);
      end else begin
        busy = 1; p_rd = r; p_en = e; p_f3 = fn; p_lo = a;
      end
    end
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst) last = 0;
    else if (instret != last) begin
      if (q.size() == 0) chk("unexpected_retire", instret, last);
      else begin
        exp_t x;
        x = q.pop_front();
        chk("write_reg", wreg, x.rd);
        chk("write_data", wdata, x.data);
        chk("reg_write", rw, x.we);
        chk("reg_write_nox0", rw0, x.we0);
        chk("instret", instret, x.cnt);
      end
      last = instret;
    end else begin
      chk("no_retire_write", rw, 0);
      chk("no_retire_write_nox0", rw0, 0);
    end
  end
  initial begin
    @(posedge clk); #1;
    chk("rst_ready", ready, 1);
    chk("rst_wreg", wreg, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rw", rw, 0);
    chk("rst_instret", instret, 0);
    @(posedge clk); #1;
    rst = 0;
    step(1, 5, 1, 2'b00, 0, 0, 32'h1234_5678, 0, 0, 0, 0);
    chk("alu_rw", rw, 1); chk("alu_rd", wreg, 5); chk("alu_data", wdata, 32'h1234_5678); chk("alu_cnt", instret, 1);
    step(1, 0, 1, 2'b10, 0, 0, 0, 32'h104, 0, 0, 0);
    chk("jal_x0_rw", rw, 0); chk("jal_x0_rw_nox0", rw0, 1); chk("jal_data", wdata, 32'h104); chk("jal_cnt", instret, 2);
    step(1, 9, 1, 2'b01, 3'd0, 0, 0, 0, 0, 1, 32'h80F1_7F82); chk("lb", wdata, 32'hFFFF_FF82);
    step(1, 9, 1, 2'b01, 3'd4, 3, 0, 0, 0, 1, 32'h80F1_7F82); chk("lbu", wdata, 32'h0000_0080);
    step(1, 9, 1, 2'b01, 3'd1, 2, 0, 0, 0, 1, 32'h80F1_7F82); chk("lh", wdata, 32'hFFFF_80F1);
    step(1, 9, 1, 2'b01, 3'd5, 0, 0, 0, 0, 1, 32'h80F1_7F82); chk("lhu", wdata, 32'h0000_7F82);
    step(1, 9, 1, 2'b01, 3'd2, 1, 0, 0, 0, 1, 32'h80F1_7F82); chk("lw", wdata, 32'h80F1_7F82);
    step(1, 9, 1, 2'b01, 3'd6, 0, 0, 0, 0, 1, 32'h80F1_7F82); chk("bad_f3_rw", rw, 0); chk("bad_f3_data", wdata, 0);
    step(1, 7, 1, 2'b01, 3'd2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 1, 2'b00, 0, 0, 32'h5555, 0, 0, 0, 0);
      chk("late_wait_rw", rw, 0);
    end
    step(1, 3, 1, 2'b00, 0, 0, 32'h5555, 0, 0, 1, 32'hDEAD_BEEF);
    chk("late_rw", rw, 1); chk("late_rd", wreg, 7); chk("late_data", wdata, 32'hDEAD_BEEF); chk("late_ready", ready, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 5'($urandom), $urandom_range(0, 4) != 0, 2'($urandom),
           3'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 2) != 0, $urandom);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 12, 1, 2'b01, 3'd2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    busy = 0; cnt = 0;
    chk("async_rst_ready", ready, 1); chk("async_rst_wreg", wreg, 0); chk("async_rst_wdata", wdata, 0);
    chk("async_rst_rw", rw, 0); chk("async_rst_instret", instret, 0); chk("async_rst_queue", q.size(), 0);
    @(posedge clk); #1;
    rst = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222);
    chk("abandoned_rw", rw, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222);
    chk("abandoned_rw2", rw, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 5'(i), 1, 2'b00, 0, 0, 32'(i * 16), 0, 0, 0, 0);
      chk("b2b_rw", rw, 1); chk("b2b_rd", wreg, i);
    end
    chk("b2b_cnt", instret, 4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
